// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-ported RAM.
// Round-robin grant with an IDLE -> ACCESS (MEM_LAT cycles) -> ACK handshake per transaction.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  output logic        cpu_stall,
  output logic [1:0]  owner
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] ACK      = 2'd2;
  localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic        r_last_dma;
  logic        r_own_dma;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_c_rdata;
  logic [31:0] r_d_rdata;

  logic w_grant;
  logic w_pick_dma;
  logic w_access;
  logic w_ack;

  // DMA wins alone, or on a tie when the CPU held the previous grant.
  always_comb begin
    w_grant    = c_req | d_req;
    w_pick_dma = d_req & (~c_req | ~r_last_dma);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last_dma <= 1'b1;
      r_own_dma  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state    <= ACCESS;
            r_cnt      <= '0;
            r_own_dma  <= w_pick_dma;
            r_last_dma <= w_pick_dma;
            r_we       <= w_pick_dma ? d_we    : c_we;
            r_addr     <= w_pick_dma ? d_addr  : c_addr;
            r_wdata    <= w_pick_dma ? d_wdata : c_wdata;
          end
        end
        ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ACK;
            r_cnt   <= '0;
            if (!r_we) begin
              if (r_own_dma) r_d_rdata <= mem_rdata;
              else           r_c_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_access  = (r_state == ACCESS);
    w_ack     = (r_state == ACK);
    mem_rd    = w_access & ~r_we;
    mem_wr    = w_access &  r_we;
    mem_addr  = w_access ? r_addr  : '0;
    mem_wdata = w_access ? r_wdata : '0;
    c_ack     = w_ack & ~r_own_dma;
    d_ack     = w_ack &  r_own_dma;
    c_rdata   = r_c_rdata;
    d_rdata   = r_d_rdata;
    cpu_stall = c_req & ~c_ack;
    owner     = (w_access | w_ack) ? (r_own_dma ? 2'b10 : 2'b01) : 2'b00;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, number of cycles each RAM command is held (legal 1..4); mem_rdata valid by end of the MEM_LAT-th command cycle (1 = combinational-read Ram32b).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 c_req  input  1  CPU port request, level; sampled only in IDLE.
REQ-005 c_we  input  1  CPU port: 1 = write, 0 = read.
REQ-006 c_addr  input  32  CPU port byte address.
REQ-007 c_wdata  input  32  CPU port write data.
REQ-008 c_rdata  output  32  CPU port read data, registered, held until next CPU read completes.
REQ-009 c_ack  output  1  CPU port completion, one-cycle pulse.
REQ-010 d_req, d_we, d_addr(32), d_wdata(32), d_rdata(32), d_ack  same directions, widths and meanings as the CPU port, for the DMA/loader port.
REQ-011 mem_addr  output  32  RAM address.
REQ-012 mem_wdata  output  32  RAM write data.
REQ-013 mem_rd  output  1  RAM read strobe.
REQ-014 mem_wr  output  1  RAM write strobe.
REQ-015 mem_rdata  input  32  RAM read data.
REQ-016 cpu_stall  output  1  freeze for the CPU control FSM.
REQ-017 owner  output  2  current grant: 00 none, 01 CPU, 10 DMA.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and ACK; every transaction is IDLE -> ACCESS (MEM_LAT cycles) -> ACK (1 cycle) -> IDLE.
REQ-019 In IDLE, any sampled request SHALL start a grant; the winner's we/addr/wdata are latched at that edge and the latched values are used for the whole transaction.
REQ-020 Sole requester is granted; when both request, the port not granted last SHALL win (round-robin); the last-owner register is set to DMA by reset, so the CPU wins the first tie.
REQ-021 In ACCESS, mem_addr/mem_wdata SHALL drive the latched values and exactly one of mem_rd/mem_wr SHALL be 1 (per latched we); a 2-bit counter counts 0..MEM_LAT-1.
REQ-022 On the edge ending the ACCESS cycle with count MEM_LAT-1, a read SHALL capture mem_rdata into the owner's rdata register; a write leaves both rdata registers unchanged.
REQ-023 In ACK, the owner's ack SHALL be 1 for exactly one cycle, mem_rd = mem_wr = 0, and no request is sampled.
REQ-024 Latency: request sampled at edge E0 -> ack high in the cycle after edge E0+MEM_LAT; throughput one transaction per MEM_LAT+2 cycles.
REQ-025 A request held high after its ack SHALL start a new transaction on the next IDLE sample; requesters drop req in the ack cycle to avoid a repeat.
REQ-026 Dropping req during ACCESS SHALL NOT abort; the transaction completes and ack still pulses.
REQ-027 Outside ACCESS, mem_rd = mem_wr = 0 and mem_addr = mem_wdata = 0.
REQ-028 cpu_stall SHALL equal c_req & ~c_ack (combinational).
REQ-029 owner SHALL be 00 in IDLE and the granted port's code in ACCESS and ACK.

Reset
REQ-030 While rst is 1 at an edge: state -> IDLE, counter -> 0, last-owner -> DMA, c_rdata = d_rdata = 0, both acks 0, all mem_* outputs 0, owner 00.
REQ-031 rst asserted mid-ACCESS or ACK SHALL abort: strobes low from the next cycle, no ack issued, rdata not updated.

Verification
REQ-032 rst high 2 cycles, then low -> all outputs 0, owner 00, cpu_stall follows c_req.
REQ-033 MEM_LAT=1, CPU read 0x10, mem_rdata 0x8C010004 -> mem_rd=1 with mem_addr 0x10 for 1 cycle, c_ack 1 cycle later, c_rdata 0x8C010004.
REQ-034 After reset, c_req and d_req held high together -> grant order CPU, DMA, CPU, DMA (owner 01,10,01,10), each ack one cycle.
REQ-035 DMA write 0xDEADBEEF to 0x40 granted, c_req rises during its ACCESS -> mem_wr=1 with addr 0x40 and wdata 0xDEADBEEF, d_ack, then CPU granted; cpu_stall=1 until c_ack cycle; c_rdata and d_rdata unchanged by the write.
REQ-036 rst pulsed during a MEM_LAT=3 CPU read -> mem_rd low next cycle, no c_ack, c_rdata 0; then MEM_LAT=3 read sampled at E0 gives mem_rd for 3 cycles and c_ack in cycle after E0+3.
